// File: rtl/mem_lsu_pipelined.sv
// Pipelined in-order load/store unit: up to DEPTH outstanding SRAM-bus requests, with in-order retirement to WB.
// Define LSU_ADDR_EXC_EN to enable the misaligned-address exception and the exc_* ports.
module mem_lsu_pipelined #(
  parameter int          DEPTH      = 2,
  parameter int          REG_ADDR_W = 5,
  parameter logic [31:0] PHYS_MASK  = 32'h1FFF_FFFF,
  localparam int         CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [2:0]            issue_op,
  input  logic [31:0]           issue_addr,
  input  logic [31:0]           issue_wdata,
  input  logic [REG_ADDR_W-1:0] issue_wd,
  input  logic [31:0]           issue_pc,
  output logic                  mem_stall,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [31:0]           data_addr,
  output logic [31:0]           data_wdata,
  input  logic [31:0]           data_rdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_wd,
  output logic [31:0]           wb_wdata,
  output logic [31:0]           wb_pc,
  output logic [CNT_W-1:0]      outstanding
`ifdef LSU_ADDR_EXC_EN
  ,
  output logic                  exc_valid,
  output logic [4:0]            exc_code,
  output logic [31:0]           exc_badvaddr
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;

  logic [2:0]            fifo_op [DEPTH];
  logic [1:0]            fifo_lo [DEPTH];
  logic [REG_ADDR_W-1:0] fifo_wd [DEPTH];
  logic [31:0]           fifo_pc [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  logic       is_store, misal, push, pop;
  logic [2:0] h_op;
  logic [1:0] h_lo;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_store = (issue_op == OP_SB) || (issue_op == OP_SH) || (issue_op == 3'b111);
    case (issue_op)
      OP_LB, OP_LBU, OP_SB: data_size = 2'b00;
      OP_LH, OP_LHU, OP_SH: data_size = 2'b01;
      default:              data_size = 2'b10;
    endcase
    case (data_size)
      2'b00:   data_wdata = {4{issue_wdata[7:0]}};
      2'b01:   data_wdata = {2{issue_wdata[15:0]}};
      default: data_wdata = issue_wdata;
    endcase
`ifdef LSU_ADDR_EXC_EN
    misal = issue_valid && (((data_size == 2'b01) && issue_addr[0]) ||
                            ((data_size == 2'b10) && (issue_addr[1:0] != 2'b00)));
`else
    misal = 1'b0;
`endif
    data_addr = issue_addr & PHYS_MASK;
    data_wr   = is_store;
    // A full FIFO blocks new requests even when a pop lands in the same cycle.
    data_req  = issue_valid && (count != DEPTH_C) && !misal;
    push      = data_req && data_addr_ok;
    pop       = data_data_ok && (count != '0);
`ifdef LSU_ADDR_EXC_EN
    exc_valid    = misal && (count == '0);
    exc_code     = exc_valid ? (is_store ? 5'd5 : 5'd4) : 5'd0;
    exc_badvaddr = exc_valid ? issue_addr : 32'h0;
    issue_ready  = push || exc_valid;
`else
    issue_ready  = push;
`endif
    mem_stall   = issue_valid && !issue_ready;
    outstanding = count;
  end

  always_comb begin
    h_op = fifo_op[rd_ptr];
    h_lo = fifo_lo[rd_ptr];
    case (h_lo)
      2'b00:   ld_byte = data_rdata[7:0];
      2'b01:   ld_byte = data_rdata[15:8];
      2'b10:   ld_byte = data_rdata[23:16];
      default: ld_byte = data_rdata[31:24];
    endcase
    ld_half  = h_lo[1] ? data_rdata[31:16] : data_rdata[15:0];
    wb_valid = pop;
    wb_we    = pop && (h_op <= OP_LW);
    wb_wd    = pop ? fifo_wd[rd_ptr] : '0;
    wb_pc    = pop ? fifo_pc[rd_ptr] : 32'h0;
    wb_wdata = 32'h0;
    if (pop) begin
      case (h_op)
        OP_LB:   wb_wdata = {{24{ld_byte[7]}}, ld_byte};
        OP_LBU:  wb_wdata = {24'h0, ld_byte};
        OP_LH:   wb_wdata = {{16{ld_half[15]}}, ld_half};
        OP_LHU:  wb_wdata = {16'h0, ld_half};
        OP_LW:   wb_wdata = data_rdata;
        default: wb_wdata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_op[i] <= '0;
        fifo_lo[i] <= '0;
        fifo_wd[i] <= '0;
        fifo_pc[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_op[wr_ptr] <= issue_op;
        fifo_lo[wr_ptr] <= issue_addr[1:0];
        fifo_wd[wr_ptr] <= issue_wd;
        fifo_pc[wr_ptr] <= issue_pc;
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu_pipelined.sv
// Self-checking bench for mem_lsu_pipelined: table of single accesses plus hand sequences for
// back-pressure, push/pop overlap, reset mid-flight and (with LSU_ADDR_EXC_EN) misalignment.
module tb_mem_lsu_pipelined;
  localparam int DEPTH = 2;
  localparam int RW    = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          issue_valid, issue_ready;
  logic [2:0]    issue_op;
  logic [31:0]   issue_addr, issue_wdata, issue_pc;
  logic [RW-1:0] issue_wd;
  logic          mem_stall, data_req, data_wr;
  logic [1:0]    data_size;
  logic [31:0]   data_addr, data_wdata, data_rdata;
  logic          data_addr_ok, data_data_ok;
  logic          wb_valid, wb_we;
  logic [RW-1:0] wb_wd;
  logic [31:0]   wb_wdata, wb_pc;
  logic [1:0]    outstanding;
`ifdef LSU_ADDR_EXC_EN
  logic          exc_valid;
  logic [4:0]    exc_code;
  logic [31:0]   exc_badvaddr;
`endif

  mem_lsu_pipelined #(.DEPTH(DEPTH), .REG_ADDR_W(RW)) dut (
    .clk(clk), .resetn(resetn),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_addr(issue_addr), .issue_wdata(issue_wdata), .issue_wd(issue_wd), .issue_pc(issue_pc),
    .mem_stall(mem_stall), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_wd(wb_wd), .wb_wdata(wb_wdata), .wb_pc(wb_pc),
    .outstanding(outstanding)
`ifdef LSU_ADDR_EXC_EN
    , .exc_valid(exc_valid), .exc_code(exc_code), .exc_badvaddr(exc_badvaddr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_daddr;
    logic [1:0]  exp_size;
    logic        exp_wr;
    logic [31:0] exp_bus_wdata;
    logic [31:0] exp_wb;
  } vec_t;

  typedef struct {
    logic          we;
    logic [RW-1:0] wd;
    logic [31:0]   wdata;
    logic [31:0]   pc;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [RW-1:0] wd, input logic [31:0] pc,
                       input logic aok, input logic dok, input logic [31:0] rd);
    @(negedge clk);
    issue_valid  = iv;
    issue_op     = op;
    issue_addr   = addr;
    issue_wdata  = wdata;
    issue_wd     = wd;
    issue_pc     = pc;
    data_addr_ok = aok;
    data_data_ok = dok;
    data_rdata   = rd;
    #1;
  endtask

  task automatic idle(input logic dok, input logic [31:0] rd);
    drive(1'b0, 3'b000, 32'h0, 32'h0, '0, 32'h0, 1'b0, dok, rd);
  endtask

  task automatic expect_wb(input logic we, input logic [RW-1:0] wd, input logic [31:0] wdata,
                           input logic [31:0] pc);
    sb_t e;
    e.we = we; e.wd = wd; e.wdata = wdata; e.pc = pc;
    sb.push_back(e);
  endtask

  // Retirement monitor: every wb_valid must match the oldest expected entry.
  always @(negedge clk) begin
    #2;
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wb_unexpected: got wb_valid=1 pc=%h expected no retirement", wb_pc);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("wb_we", {31'h0, wb_we}, {31'h0, e.we});
        chk("wb_wdata", wb_wdata, e.wdata);
        chk("wb_pc", wb_pc, e.pc);
        if (e.we) chk("wb_wd", {27'h0, wb_wd}, {27'h0, e.wd});
      end
    end
  end

  initial begin
    vecs[0]  = '{3'b100, 32'h8000_0010, 32'h0,         32'h1234_5678, 32'h0000_0010, 2'b10, 1'b0, 32'h0,         32'h1234_5678};
    vecs[1]  = '{3'b000, 32'h8000_0003, 32'h0,         32'h80AB_CDEF, 32'h0000_0003, 2'b00, 1'b0, 32'h0,         32'hFFFF_FF80};
    vecs[2]  = '{3'b001, 32'h8000_0003, 32'h0,         32'h80AB_CDEF, 32'h0000_0003, 2'b00, 1'b0, 32'h0,         32'h0000_0080};
    vecs[3]  = '{3'b000, 32'hA000_0001, 32'h0,         32'h1122_3344, 32'h0000_0001, 2'b00, 1'b0, 32'h0,         32'h0000_0033};
    vecs[4]  = '{3'b000, 32'h8000_0002, 32'h0,         32'h007F_0000, 32'h0000_0002, 2'b00, 1'b0, 32'h0,         32'h0000_007F};
    vecs[5]  = '{3'b010, 32'h8000_0002, 32'h0,         32'h8001_7FFF, 32'h0000_0002, 2'b01, 1'b0, 32'h0,         32'hFFFF_8001};
    vecs[6]  = '{3'b011, 32'h8000_0000, 32'h0,         32'h8001_F00D, 32'h0000_0000, 2'b01, 1'b0, 32'h0,         32'h0000_F00D};
    vecs[7]  = '{3'b010, 32'h8000_0000, 32'h0,         32'h1234_F00D, 32'h0000_0000, 2'b01, 1'b0, 32'h0,         32'hFFFF_F00D};
    vecs[8]  = '{3'b011, 32'h8000_0006, 32'h0,         32'hBEEF_0000, 32'h0000_0006, 2'b01, 1'b0, 32'h0,         32'h0000_BEEF};
    vecs[9]  = '{3'b101, 32'hBFC0_0005, 32'h1234_56A5, 32'h0,         32'h1FC0_0005, 2'b00, 1'b1, 32'hA5A5_A5A5, 32'h0};
    vecs[10] = '{3'b110, 32'h8000_0100, 32'hAAAA_BEEF, 32'h0,         32'h0000_0100, 2'b01, 1'b1, 32'hBEEF_BEEF, 32'h0};
    vecs[11] = '{3'b111, 32'h8000_0104, 32'hCAFE_F00D, 32'h0,         32'h0000_0104, 2'b10, 1'b1, 32'hCAFE_F00D, 32'h0};

    resetn = 1'b0;
    issue_valid = 1'b0; issue_op = 3'b000; issue_addr = 32'h0; issue_wdata = 32'h0;
    issue_wd = '0; issue_pc = 32'h0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_outstanding", {30'h0, outstanding}, 32'h0);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_data_req", {31'h0, data_req}, 32'h0);
    chk("rst_issue_ready", {31'h0, issue_ready}, 32'h0);
    chk("rst_wb_pc", wb_pc, 32'h0);
    resetn = 1'b1;

    // Table: accept with addr_ok in the same cycle, data_ok on the next.
    for (int i = 0; i < 12; i++) begin
      logic [RW-1:0] wd;
      logic [31:0]   pc;
      wd = RW'(i + 1);
      pc = 32'h0040_0000 + 32'(i * 4);
      drive(1'b1, vecs[i].op, vecs[i].addr, vecs[i].wdata, wd, pc, 1'b1, 1'b0, 32'h0);
      chk($sformatf("v%0d_outstanding0", i), {30'h0, outstanding}, 32'h0);
      chk($sformatf("v%0d_data_req", i), {31'h0, data_req}, 32'h1);
      chk($sformatf("v%0d_issue_ready", i), {31'h0, issue_ready}, 32'h1);
      chk($sformatf("v%0d_data_addr", i), data_addr, vecs[i].exp_daddr);
      chk($sformatf("v%0d_data_size", i), {30'h0, data_size}, {30'h0, vecs[i].exp_size});
      chk($sformatf("v%0d_data_wr", i), {31'h0, data_wr}, {31'h0, vecs[i].exp_wr});
      if (vecs[i].exp_wr) chk($sformatf("v%0d_data_wdata", i), data_wdata, vecs[i].exp_bus_wdata);
      if (issue_ready === 1'b1) expect_wb(!vecs[i].exp_wr, wd, vecs[i].exp_wb, pc);
      idle(1'b1, vecs[i].rdata);
      chk($sformatf("v%0d_outstanding1", i), {30'h0, outstanding}, 32'h1);
      chk($sformatf("v%0d_wb_valid", i), {31'h0, wb_valid}, 32'h1);
    end
    idle(1'b0, 32'h0);

    // LW with data_ok two cycles after acceptance.
    drive(1'b1, 3'b100, 32'h8000_0010, 32'h0, 5'd7, 32'h0000_0100, 1'b1, 1'b0, 32'h0);
    if (issue_ready === 1'b1) expect_wb(1'b1, 5'd7, 32'h1234_5678, 32'h0000_0100);
    idle(1'b0, 32'h0);
    chk("lat_wb_idle", {31'h0, wb_valid}, 32'h0);
    chk("lat_outstanding", {30'h0, outstanding}, 32'h1);
    idle(1'b1, 32'h1234_5678);
    chk("lat_wb_valid", {31'h0, wb_valid}, 32'h1);

    // Three back-to-back loads against DEPTH=2 with data_ok withheld.
    drive(1'b1, 3'b100, 32'h8000_0200, 32'h0, 5'd1, 32'h0000_0200, 1'b1, 1'b0, 32'h0);
    chk("bp_a_ready", {31'h0, issue_ready}, 32'h1);
    if (issue_ready === 1'b1) expect_wb(1'b1, 5'd1, 32'h0000_00A1, 32'h0000_0200);
    drive(1'b1, 3'b100, 32'h8000_0204, 32'h0, 5'd2, 32'h0000_0204, 1'b1, 1'b0, 32'h0);
    chk("bp_b_ready", {31'h0, issue_ready}, 32'h1);
    if (issue_ready === 1'b1) expect_wb(1'b1, 5'd2, 32'h0000_00A2, 32'h0000_0204);
    drive(1'b1, 3'b100, 32'h8000_0208, 32'h0, 5'd3, 32'h0000_0208, 1'b1, 1'b0, 32'h0);
    chk("bp_full_req", {31'h0, data_req}, 32'h0);
    chk("bp_full_stall", {31'h0, mem_stall}, 32'h1);
    chk("bp_full_outstanding", {30'h0, outstanding}, 32'h2);
    drive(1'b1, 3'b100, 32'h8000_0208, 32'h0, 5'd3, 32'h0000_0208, 1'b1, 1'b1, 32'h0000_00A1);
    chk("bp_nobypass_req", {31'h0, data_req}, 32'h0);
    chk("bp_nobypass_stall", {31'h0, mem_stall}, 32'h1);
    chk("bp_pop_a", {31'h0, wb_valid}, 32'h1);
    drive(1'b1, 3'b100, 32'h8000_0208, 32'h0, 5'd3, 32'h0000_0208, 1'b1, 1'b1, 32'h0000_00A2);
    chk("pp_ready", {31'h0, issue_ready}, 32'h1);
    chk("pp_outstanding_before", {30'h0, outstanding}, 32'h1);
    if (issue_ready === 1'b1) expect_wb(1'b1, 5'd3, 32'h0000_00A3, 32'h0000_0208);
    idle(1'b1, 32'h0000_00A3);
    chk("pp_outstanding_after", {30'h0, outstanding}, 32'h1);
    idle(1'b0, 32'h0);
    chk("pp_drained", {30'h0, outstanding}, 32'h0);
    idle(1'b1, 32'hDEAD_BEEF);
    chk("stray_dok_wb", {31'h0, wb_valid}, 32'h0);
    chk("stray_dok_outstanding", {30'h0, outstanding}, 32'h0);

    // Reset while a load is in flight; its later data_ok must be ignored.
    drive(1'b1, 3'b100, 32'h8000_0300, 32'h0, 5'd4, 32'h0000_0300, 1'b1, 1'b0, 32'h0);
    if (issue_ready === 1'b1) expect_wb(1'b1, 5'd4, 32'h0, 32'h0000_0300);
    idle(1'b0, 32'h0);
    chk("mid_outstanding", {30'h0, outstanding}, 32'h1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    sb.delete();
    chk("mrst_outstanding", {30'h0, outstanding}, 32'h0);
    chk("mrst_data_req", {31'h0, data_req}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    idle(1'b1, 32'h5555_5555);
    chk("mrst_stray_wb", {31'h0, wb_valid}, 32'h0);
    chk("mrst_stray_outstanding", {30'h0, outstanding}, 32'h0);

`ifdef LSU_ADDR_EXC_EN
    drive(1'b1, 3'b100, 32'h8000_0002, 32'h0, 5'd5, 32'h0000_0400, 1'b1, 1'b0, 32'h0);
    chk("exc_lw_req", {31'h0, data_req}, 32'h0);
    chk("exc_lw_ready", {31'h0, issue_ready}, 32'h1);
    chk("exc_lw_valid", {31'h0, exc_valid}, 32'h1);
    chk("exc_lw_code", {27'h0, exc_code}, 32'h4);
    chk("exc_lw_badvaddr", exc_badvaddr, 32'h8000_0002);
    drive(1'b1, 3'b110, 32'h8000_0101, 32'h0, 5'd0, 32'h0000_0404, 1'b1, 1'b0, 32'h0);
    chk("exc_sh_code", {27'h0, exc_code}, 32'h5);
    chk("exc_sh_badvaddr", exc_badvaddr, 32'h8000_0101);
    drive(1'b1, 3'b100, 32'h8000_0020, 32'h0, 5'd6, 32'h0000_0408, 1'b1, 1'b0, 32'h0);
    if (issue_ready === 1'b1) expect_wb(1'b1, 5'd6, 32'h0BAD_F00D, 32'h0000_0408);
    drive(1'b1, 3'b100, 32'h8000_0022, 32'h0, 5'd7, 32'h0000_040C, 1'b1, 1'b0, 32'h0);
    chk("exc_busy_ready", {31'h0, issue_ready}, 32'h0);
    chk("exc_busy_valid", {31'h0, exc_valid}, 32'h0);
    chk("exc_busy_stall", {31'h0, mem_stall}, 32'h1);
    idle(1'b1, 32'h0BAD_F00D);
    idle(1'b0, 32'h0);
`endif

    repeat (3) idle(1'b0, 32'h0);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
